reg_wb_scoreboard: RTL and testbench
====================================

Name: reg_wb_scoreboard

Overview:
- Controls the single write port of the 32x32 register file and tracks pending destination registers.
- Two writeback requesters share the port under round-robin arbitration: A is the single-cycle ALU path, B is the long-latency mult/div/load path.
- A per-register busy scoreboard stalls instruction issue on RAW and WAW hazards until the pending write has landed in the register file.
- Sits between decode/issue, the two execution paths and the register file write inputs.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register index width (clog2 of NREG).
- DW, 32, data width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- iss_valid  in  1  decode presents an instruction for issue
- iss_rs  in  AW  source register 1
- iss_rt  in  AW  source register 2
- iss_rd  in  AW  destination register
- iss_wr  in  1  instruction writes iss_rd
- iss_ready  out  1  no hazard; issue fires when iss_valid & iss_ready
- wa_valid  in  1  requester A writeback request
- wa_reg  in  AW  requester A destination
- wa_data  in  DW  requester A data
- wa_ready  out  1  requester A granted this cycle
- wb_valid  in  1  requester B writeback request
- wb_reg  in  AW  requester B destination
- wb_data  in  DW  requester B data
- wb_ready  out  1  requester B granted this cycle
- RegWrite  out  1  register file write enable (registered)
- w_reg  out  AW  register file write index (registered)
- w_data  out  DW  register file write data (registered)
- busy_map  out  NREG  scoreboard state; bit 0 is always 0
- sb_err  out  1  sticky flag: writeback to a non-busy register

Behaviour:
- Reset (synchronous): busy_map=0, RegWrite=0, w_reg=0, w_data=0, sb_err=0, last_grant=B so that A wins the first tie.
- Hazard check, combinational from registered busy_map: iss_ready = !(busy[rs] | busy[rt] | (iss_wr & busy[rd])).
  - busy[0] is always 0, so register 0 never stalls.
- No bypass: a register becomes readable the cycle after the edge at which its write lands.
- Issue fire with iss_wr=1 and iss_rd!=0 sets busy[iss_rd] at the next edge. iss_wr=0 or iss_rd=0 sets nothing.
- Arbitration (combinational ready):
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted last time wins. last_grant updates only on an actual grant.
  - Neither valid: no grant, last_grant holds.
- Write stage, one-cycle latency: a grant at edge N loads w_reg and w_data from the winner and sets RegWrite=1 for the cycle after edge N. The register file writes at edge N+1.
  - Without a grant, RegWrite=0 and w_reg/w_data hold their values.
  - A grant with reg=0 is accepted (ready=1) but RegWrite stays 0 and sb_err is unaffected.
- Retire: at an edge where RegWrite=1, busy[w_reg] clears. This is the same edge the register file writes.
- Error: a grant whose reg!=0 and whose busy bit is 0 (and not already in flight in the write stage) sets sb_err. The write is still performed. sb_err clears only on reset.
- Simultaneous events:
  - Set (issue) and clear (retire) of different registers in the same edge both apply.
  - Set and clear of the same register cannot coincide, because issue sees busy[rd]=1 and stalls.
- Back-to-back grants every cycle are legal; the port sustains 1 write/cycle.
- Reset asserted mid-operation discards any in-flight write (RegWrite=0 next cycle) and clears all busy bits.

Test Plan:
1. Reset, then issue rd=5 iss_wr=1 -> busy_map=0x20; next issue with rs=5 has iss_ready=0. wa_valid, wa_reg=5, wa_data=0xDEADBEEF -> next cycle RegWrite=1, w_reg=5, w_data=0xDEADBEEF; after that edge busy_map=0 and iss_ready=1.
2. Busy r3 and r4; wa and wb both valid for 3 consecutive cycles (A: r3, B: r4, then repeat) -> grants A, B, A; RegWrite high for 3 consecutive cycles.
3. Issue rd=0 iss_wr=1 -> busy_map stays 0. wb_valid with wb_reg=0 -> wb_ready=1, RegWrite stays 0.
4. wa_reg=7 with busy[7]=0 -> write performed and sb_err=1; sb_err stays 1 until reset.
5. Issue rd=9 and retire r2 at the same edge -> busy_map goes from 0x004 to 0x200. Then an instruction with iss_rd=9 and iss_wr=1 stalls (WAW).
6. Grant r6 then assert reset at the next edge -> RegWrite=0, busy_map=0, sb_err=0, and A wins the first tie after reset.

Source files
------------

// File: rtl/reg_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_wb_scoreboard
//
// Owns the single write port of the register file and the per-register busy
// scoreboard used to hold off instruction issue on RAW/WAW hazards.
//
// Two writeback requesters share the port under round-robin arbitration:
//   A : single-cycle ALU path
//   B : long-latency mult/div/load path
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   iss_valid/rs/rt/rd/wr issue request from decode
//   iss_ready             no hazard against the busy scoreboard
//   wa_valid/reg/data     requester A writeback, wa_ready = A granted
//   wb_valid/reg/data     requester B writeback, wb_ready = B granted
//   RegWrite/w_reg/w_data registered register-file write port
//   busy_map              scoreboard state (bit 0 always 0)
//   sb_err                sticky: writeback hit a register that was not busy
// ---------------------------------------------------------------------------
module reg_wb_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rs,
    input  logic [AW-1:0]   iss_rt,
    input  logic [AW-1:0]   iss_rd,
    input  logic            iss_wr,
    output logic            iss_ready,

    input  logic            wa_valid,
    input  logic [AW-1:0]   wa_reg,
    input  logic [DW-1:0]   wa_data,
    output logic            wa_ready,

    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_reg,
    input  logic [DW-1:0]   wb_data,
    output logic            wb_ready,

    output logic            RegWrite,
    output logic [AW-1:0]   w_reg,
    output logic [DW-1:0]   w_data,
    output logic [NREG-1:0] busy_map,
    output logic            sb_err
);

    // Remembers which requester won most recently; the other one wins a tie.
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    grant_e          last_q, last_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            regwrite_q, regwrite_d;
    logic [AW-1:0]   w_reg_q, w_reg_d;
    logic [DW-1:0]   w_data_q, w_data_d;
    logic            sb_err_q, sb_err_d;

    logic            grant_a, grant_b;
    logic            win_valid;
    logic [AW-1:0]   win_reg;
    logic [DW-1:0]   win_data;
    logic            win_nz;
    logic            win_inflight;
    logic            issue_set;

    // ------------------------------------------------------------------
    // Hazard check: purely from registered busy bits, no bypass.
    // ------------------------------------------------------------------
    always_comb begin
        iss_ready = !(busy_q[iss_rs] | busy_q[iss_rt] | (iss_wr & busy_q[iss_rd]));
    end

    assign issue_set = iss_valid & iss_ready & iss_wr & (iss_rd != '0);

    // ------------------------------------------------------------------
    // Round-robin arbiter (next-state of last_q plus grant outputs)
    // ------------------------------------------------------------------
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        last_d  = last_q;
        if (wa_valid && wb_valid) begin
            if (last_q == GRANT_B) begin
                grant_a = 1'b1;
            end else begin
                grant_b = 1'b1;
            end
        end else if (wa_valid) begin
            grant_a = 1'b1;
        end else if (wb_valid) begin
            grant_b = 1'b1;
        end
        if (grant_a) begin
            last_d = GRANT_A;
        end else if (grant_b) begin
            last_d = GRANT_B;
        end
    end

    assign wa_ready  = grant_a;
    assign wb_ready  = grant_b;
    assign win_valid = grant_a | grant_b;
    assign win_reg   = grant_a ? wa_reg  : wb_reg;
    assign win_data  = grant_a ? wa_data : wb_data;
    // Writes to r0 are accepted but dropped before the write stage.
    assign win_nz    = win_valid & (win_reg != '0);
    // A write for the same register already sitting in the write stage
    // still has its busy bit set, so it is not an orphan writeback.
    assign win_inflight = regwrite_q & (w_reg_q == win_reg);

    // ------------------------------------------------------------------
    // Write stage, scoreboard and error flag next-state
    // ------------------------------------------------------------------
    always_comb begin
        regwrite_d = win_nz;
        w_reg_d    = w_reg_q;
        w_data_d   = w_data_q;
        if (win_nz) begin
            w_reg_d  = win_reg;
            w_data_d = win_data;
        end

        sb_err_d = sb_err_q | (win_nz & ~busy_q[win_reg] & ~win_inflight);

        // Retire and issue may hit different registers on the same edge;
        // the same register cannot collide because issue stalls on busy[rd].
        busy_d = busy_q;
        if (regwrite_q) begin
            busy_d[w_reg_q] = 1'b0;
        end
        if (issue_set) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= GRANT_B;
            busy_q     <= '0;
            regwrite_q <= 1'b0;
            w_reg_q    <= '0;
            w_data_q   <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            last_q     <= last_d;
            busy_q     <= busy_d;
            regwrite_q <= regwrite_d;
            w_reg_q    <= w_reg_d;
            w_data_q   <= w_data_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign RegWrite = regwrite_q;
    assign w_reg    = w_reg_q;
    assign w_data   = w_data_q;
    assign busy_map = busy_q;
    assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_wb_scoreboard
//
// Directed stimulus for reg_wb_scoreboard. A behavioural model tracks the set
// of pending registers, the pending register-file write and the tie-break
// owner; a compare process checks every DUT output against it each cycle,
// and the stimulus pins key points with hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_reg_wb_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rs = '0, iss_rt = '0, iss_rd = '0;
    logic        iss_wr = 1'b0;
    logic        iss_ready;
    logic        wa_valid = 1'b0;
    logic [4:0]  wa_reg = '0;
    logic [31:0] wa_data = '0;
    logic        wa_ready;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_reg = '0;
    logic [31:0] wb_data = '0;
    logic        wb_ready;
    logic        RegWrite;
    logic [4:0]  w_reg;
    logic [31:0] w_data;
    logic [31:0] busy_map;
    logic        sb_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_wb_scoreboard #(.NREG(32), .AW(5), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
        .iss_rd(iss_rd), .iss_wr(iss_wr), .iss_ready(iss_ready),
        .wa_valid(wa_valid), .wa_reg(wa_reg), .wa_data(wa_data), .wa_ready(wa_ready),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
        .RegWrite(RegWrite), .w_reg(w_reg), .w_data(w_data),
        .busy_map(busy_map), .sb_err(sb_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit        m_init = 0;
    bit [31:0] m_busy;        // set of registers with a write outstanding
    bit        m_last_b;      // 1: B was granted most recently
    bit        m_wv;          // a register-file write is presented this cycle
    bit [4:0]  m_wr;
    bit [31:0] m_wd;
    bit        m_err;

    function automatic bit m_can_issue();
        return !(m_busy[iss_rs] || m_busy[iss_rt] || (iss_wr && m_busy[iss_rd]));
    endfunction

    function automatic bit m_a_wins();
        return wa_valid && (!wb_valid || m_last_b);
    endfunction

    function automatic bit m_b_wins();
        return wb_valid && (!wa_valid || !m_last_b);
    endfunction

    always @(posedge clk) begin
        bit [31:0] nb;
        bit        ga, gb;
        bit [4:0]  r;
        if (reset) begin
            m_init   = 1;
            m_busy   = '0;
            m_last_b = 1;
            m_wv     = 0;
            m_wr     = '0;
            m_wd     = '0;
            m_err    = 0;
        end else if (m_init) begin
            ga = m_a_wins();
            gb = m_b_wins();
            nb = m_busy;
            if (m_wv) nb[m_wr] = 1'b0;
            if (iss_valid && m_can_issue() && iss_wr && iss_rd != 0) nb[iss_rd] = 1'b1;
            if (ga || gb) begin
                r = ga ? wa_reg : wb_reg;
                m_last_b = gb;
                if (r != 0) begin
                    if (!m_busy[r] && !(m_wv && m_wr == r)) m_err = 1;
                    m_wv = 1;
                    m_wr = r;
                    m_wd = ga ? wa_data : wb_data;
                end else begin
                    m_wv = 0;
                end
            end else begin
                m_wv = 0;
            end
            m_busy = nb;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            chk("iss_ready", {31'd0, iss_ready}, {31'd0, m_can_issue()});
            chk("wa_ready",  {31'd0, wa_ready},  {31'd0, m_a_wins()});
            chk("wb_ready",  {31'd0, wb_ready},  {31'd0, m_b_wins()});
            chk("RegWrite",  {31'd0, RegWrite},  {31'd0, m_wv});
            if (m_wv) begin
                chk("w_reg",  {27'd0, w_reg}, {27'd0, m_wr});
                chk("w_data", w_data, m_wd);
            end
            chk("busy_map", busy_map, m_busy);
            chk("sb_err",   {31'd0, sb_err}, {31'd0, m_err});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_rd = 0; iss_wr = 0;
        wa_valid = 0; wb_valid = 0;
    endtask

    task automatic issue(input logic [4:0] rd);
        idle();
        iss_valid = 1; iss_wr = 1; iss_rd = rd;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("rst_busy", busy_map, 32'h0);
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_w_reg", {27'd0, w_reg}, 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_sb_err", {31'd0, sb_err}, 32'd0);

        // 1: RAW stall, write, retire
        issue(5'd5);
        tick();
        idle();
        iss_valid = 1; iss_rs = 5; iss_rd = 6; iss_wr = 1;
        wa_valid = 1; wa_reg = 5; wa_data = 32'hDEADBEEF;
        #1;
        chk("t1_busy", busy_map, 32'h20);
        chk("t1_raw_stall", {31'd0, iss_ready}, 32'd0);
        chk("t1_wa_ready", {31'd0, wa_ready}, 32'd1);
        tick();
        idle();
        #1;
        chk("t1_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("t1_w_reg", {27'd0, w_reg}, 32'd5);
        chk("t1_w_data", w_data, 32'hDEADBEEF);
        tick();
        iss_valid = 1; iss_rs = 5;
        #1;
        chk("t1_retired", busy_map, 32'h0);
        chk("t1_ready", {31'd0, iss_ready}, 32'd1);
        idle();

        // 2: round-robin A, B, A with back-to-back writes
        do_reset();
        issue(5'd3); tick();
        issue(5'd4); tick();
        issue(5'd10); tick();
        idle();
        wa_valid = 1; wa_reg = 3; wa_data = 32'h33;
        wb_valid = 1; wb_reg = 4; wb_data = 32'h44;
        #1;
        chk("t2_g1_a", {31'd0, wa_ready}, 32'd1);
        chk("t2_g1_b", {31'd0, wb_ready}, 32'd0);
        tick();
        wa_reg = 10; wa_data = 32'hAA;
        #1;
        chk("t2_g2_a", {31'd0, wa_ready}, 32'd0);
        chk("t2_g2_b", {31'd0, wb_ready}, 32'd1);
        chk("t2_w1", {27'd0, w_reg}, 32'd3);
        tick();
        #1;
        chk("t2_g3_a", {31'd0, wa_ready}, 32'd1);
        chk("t2_w2", {27'd0, w_reg}, 32'd4);
        chk("t2_rw2", {31'd0, RegWrite}, 32'd1);
        tick();
        idle();
        #1;
        chk("t2_w3", {27'd0, w_reg}, 32'd10);
        chk("t2_rw3", {31'd0, RegWrite}, 32'd1);
        tick();
        #1;
        chk("t2_busy_clear", busy_map, 32'h0);
        chk("t2_no_err", {31'd0, sb_err}, 32'd0);

        // 3: r0 is never tracked or written
        issue(5'd0); tick();
        idle();
        wb_valid = 1; wb_reg = 0; wb_data = 32'h1234;
        #1;
        chk("t3_busy", busy_map, 32'h0);
        chk("t3_wb_ready", {31'd0, wb_ready}, 32'd1);
        tick();
        idle();
        #1;
        chk("t3_no_write", {31'd0, RegWrite}, 32'd0);
        chk("t3_no_err", {31'd0, sb_err}, 32'd0);

        // 4: orphan writeback flags sb_err, write still happens
        wa_valid = 1; wa_reg = 7; wa_data = 32'h77;
        tick();
        idle();
        #1;
        chk("t4_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("t4_w_reg", {27'd0, w_reg}, 32'd7);
        chk("t4_sb_err", {31'd0, sb_err}, 32'd1);
        tick(); tick();
        chk("t4_sticky", {31'd0, sb_err}, 32'd1);

        // 5: issue r9 while r2 retires on the same edge, then WAW stall
        issue(5'd2); tick();
        idle();
        wa_valid = 1; wa_reg = 2; wa_data = 32'h22;
        tick();
        issue(5'd9);
        #1;
        chk("t5_before", busy_map, 32'h4);
        chk("t5_rw", {31'd0, RegWrite}, 32'd1);
        tick();
        issue(5'd9);
        #1;
        chk("t5_after", busy_map, 32'h200);
        chk("t5_waw_stall", {31'd0, iss_ready}, 32'd0);
        iss_wr = 0;
        #1;
        chk("t5_no_wr_ready", {31'd0, iss_ready}, 32'd1);
        idle();
        tick();

        // 6: reset discards an in-flight write; A wins the first tie after
        issue(5'd6); tick();
        issue(5'd11); tick();
        idle();
        wa_valid = 1; wa_reg = 6; wa_data = 32'h66;
        tick();
        wa_reg = 11; wa_data = 32'h11;
        reset = 1;
        #1;
        chk("t6_inflight", {31'd0, RegWrite}, 32'd1);
        chk("t6_inflight_reg", {27'd0, w_reg}, 32'd6);
        tick();
        reset = 0;
        idle();
        #1;
        chk("t6_rst_rw", {31'd0, RegWrite}, 32'd0);
        chk("t6_rst_busy", busy_map, 32'h0);
        chk("t6_rst_err", {31'd0, sb_err}, 32'd0);
        issue(5'd12); tick();
        issue(5'd13); tick();
        idle();
        wa_valid = 1; wa_reg = 12; wa_data = 32'hC;
        wb_valid = 1; wb_reg = 13; wb_data = 32'hD;
        #1;
        chk("t6_tie_a", {31'd0, wa_ready}, 32'd1);
        chk("t6_tie_b", {31'd0, wb_ready}, 32'd0);
        tick();
        idle();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
